// File: rtl/rfid_pkg.sv
// Shared types and constants for the RFID receive path.
// Holds the collector state encoding and the Gen2 CRC-16 helpers.
package rfid_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } fc_state_t;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    function automatic int bank_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    // One MSB-first step of the serial CRC-16.
    function automatic logic [15:0] crc16_next(
        input logic [15:0] crc,
        input logic        bit_in
    );
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Serial EPC Gen2 CRC-16, one bit per enabled cycle.
// Shared between the receive collector and the transmit path.
module crc16_serial
    import rfid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC16_PRESET;
        end else if (init) begin
            crc <= CRC16_PRESET;
        end else if (en) begin
            crc <= crc16_next(crc, bit_in);
        end
    end

endmodule

// File: rtl/frame_collector.sv
// Assembles tag reply frames behind the preamble detector and
// hands them to the reader controller with a CRC verdict.
module frame_collector
    import rfid_pkg::*;
#(
    parameter int MAX_BITS   = 128,
    parameter int BANKS      = 9,
    parameter int TIMEOUT    = 4096,
    parameter int BANK_WIDTH = bank_width(BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_dat,
    input  logic                  in_vld,
    input  logic                  preamble_detected,
    input  logic [BANK_WIDTH-1:0] frequency_bank,
    input  logic [7:0]            frame_len,
    input  logic                  crc_en,
    output logic [MAX_BITS-1:0]   frame_dat,
    output logic [7:0]            frame_bits,
    output logic [BANK_WIDTH-1:0] frame_bank,
    output logic                  crc_ok,
    output logic                  frame_vld,
    input  logic                  frame_rdy,
    output logic                  timeout,
    output logic                  len_err,
    output logic                  drop
);

    localparam int TW = $clog2(TIMEOUT + 1);

    fc_state_t     state;
    logic [7:0]    cnt;
    logic [TW-1:0] tcnt;
    logic          crc_en_q;
    logic [15:0]   crc;
    logic          bad_len;
    logic          can_arm;
    logic          arm;
    logic          take_bit;
    logic [7:0]    cnt_nxt;

    assign bad_len  = (frame_len == 8'd0)
                   || (int'(frame_len) > MAX_BITS)
                   || (crc_en && (frame_len < 8'd17));
    assign can_arm  = (state == IDLE) || (state == COLLECT);
    assign arm      = preamble_detected && can_arm && !bad_len;
    assign take_bit = (state == COLLECT) && in_vld && !preamble_detected;
    assign cnt_nxt  = cnt + 8'd1;

    crc16_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (arm),
        .en     (take_bit),
        .bit_in (in_dat),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tcnt       <= '0;
            crc_en_q   <= 1'b0;
            frame_dat  <= '0;
            frame_bits <= '0;
            frame_bank <= '0;
            crc_ok     <= 1'b0;
            frame_vld  <= 1'b0;
            timeout    <= 1'b0;
            len_err    <= 1'b0;
            drop       <= 1'b0;
        end else begin
            timeout <= 1'b0;
            len_err <= 1'b0;
            drop    <= 1'b0;
            if (arm) begin
                // A fresh preamble also restarts a collection in progress.
                state      <= COLLECT;
                frame_bits <= frame_len;
                frame_bank <= frequency_bank;
                crc_en_q   <= crc_en;
                frame_dat  <= '0;
                cnt        <= '0;
                tcnt       <= '0;
                crc_ok     <= 1'b0;
            end else if (preamble_detected && can_arm) begin
                len_err <= 1'b1;
                state   <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    COLLECT: begin
                        if (in_vld) begin
                            frame_dat <= {frame_dat[MAX_BITS-2:0], in_dat};
                            cnt       <= cnt_nxt;
                            tcnt      <= '0;
                            if (cnt_nxt == frame_bits) begin
                                state     <= HOLD;
                                frame_vld <= 1'b1;
                                crc_ok    <= !crc_en_q
                                          || (crc16_next(crc, in_dat) == CRC16_RESIDUE);
                            end
                        end else if (tcnt == TW'(TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (preamble_detected) drop <= 1'b1;
                        if (frame_rdy) begin
                            frame_vld <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_collector.sv
// Directed self-checking bench for frame_collector.
module tb_frame_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_dat = 1'b0;
    logic         in_vld = 1'b0;
    logic         preamble_detected = 1'b0;
    logic [3:0]   frequency_bank = '0;
    logic [7:0]   frame_len = '0;
    logic         crc_en = 1'b0;
    logic [127:0] frame_dat;
    logic [7:0]   frame_bits;
    logic [3:0]   frame_bank;
    logic         crc_ok;
    logic         frame_vld;
    logic         frame_rdy = 1'b0;
    logic         timeout;
    logic         len_err;
    logic         drop;

    int checks = 0;
    int errors = 0;

    frame_collector dut (
        .clk               (clk),
        .rst               (rst),
        .in_dat            (in_dat),
        .in_vld            (in_vld),
        .preamble_detected (preamble_detected),
        .frequency_bank    (frequency_bank),
        .frame_len         (frame_len),
        .crc_en            (crc_en),
        .frame_dat         (frame_dat),
        .frame_bits        (frame_bits),
        .frame_bank        (frame_bank),
        .crc_ok            (crc_ok),
        .frame_vld         (frame_vld),
        .frame_rdy         (frame_rdy),
        .timeout           (timeout),
        .len_err           (len_err),
        .drop              (drop)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] len, input logic ce, input logic [3:0] bank);
        frame_len = len;
        crc_en = ce;
        frequency_bank = bank;
        preamble_detected = 1'b1;
        tick();
        preamble_detected = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] w, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_vld = 1'b1;
            in_dat = w[i];
            tick();
            in_vld = 1'b0;
        end
    endtask

    initial begin
        logic [111:0] pc_epc;
        logic [15:0]  c;
        logic [127:0] epc;
        logic [127:0] bad;
        logic [15:0]  rn16;
        logic [31:0]  w32;
        int drops;
        int tn;
        bit tflag;
        bit vseen;

        // Reset state
        #1;
        chk("rst_dat", frame_dat, 128'h0);
        chk("rst_bits", frame_bits, 0);
        chk("rst_bank", frame_bank, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_vld", frame_vld, 0);
        chk("rst_pulses", {timeout, len_err, drop}, 0);
        tick();
        rst = 1'b1;
        tick();

        // RN16, no CRC, random gaps
        rn16 = 16'hA5C3;
        pulse(16, 1'b0, 4'd3);
        send_word(128'(rn16 >> 1), 15, 1'b1);
        chk("rn16_vld_early", frame_vld, 0);
        send_word(128'(rn16[0]), 1, 1'b0);
        chk("rn16_vld", frame_vld, 1);
        chk("rn16_dat", frame_dat, 128'hA5C3);
        chk("rn16_bits", frame_bits, 16);
        chk("rn16_bank", frame_bank, 3);
        chk("rn16_crc_ok", crc_ok, 1);
        frame_rdy = 1'b1;
        tick();
        frame_rdy = 1'b0;
        chk("rn16_xfer", frame_vld, 0);

        // EPC reply with a good CRC
        pc_epc = {16'h3000, 96'hE280_1160_6000_0209_1234_5678};
        c = 16'hFFFF;
        for (int i = 111; i >= 0; i--) c = crc_step(c, pc_epc[i]);
        epc = {pc_epc, ~c};
        pulse(128, 1'b1, 4'd8);
        send_word(epc, 128, 1'b0);
        chk("epc_vld", frame_vld, 1);
        chk("epc_dat", frame_dat, epc);
        chk("epc_crc_ok", crc_ok, 1);
        chk("epc_bank", frame_bank, 8);

        // Transfer with a coincident preamble: drop, not armed
        frame_len = 16;
        crc_en = 1'b0;
        frame_rdy = 1'b1;
        preamble_detected = 1'b1;
        tick();
        frame_rdy = 1'b0;
        preamble_detected = 1'b0;
        chk("coinc_vld", frame_vld, 0);
        chk("coinc_drop", drop, 1);
        send_word(128'h0, 16, 1'b0);
        chk("coinc_not_armed_vld", frame_vld, 0);
        chk("coinc_not_armed_dat", frame_dat, epc);

        // EPC with bit 40 flipped
        bad = epc ^ (128'h1 << 40);
        pulse(128, 1'b1, 4'd1);
        send_word(bad, 128, 1'b0);
        chk("bad_vld", frame_vld, 1);
        chk("bad_crc_ok", crc_ok, 0);

        // Backpressure with a preamble while held
        drops = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc == 20) preamble_detected = 1'b1;
            frame_len = 16;
            crc_en = 1'b0;
            in_vld = 1'b1;
            in_dat = 1'b1;
            tick();
            preamble_detected = 1'b0;
            if (drop) drops++;
        end
        in_vld = 1'b0;
        chk("bp_drops", drops, 1);
        chk("bp_vld", frame_vld, 1);
        chk("bp_dat", frame_dat, bad);
        chk("bp_bits", frame_bits, 128);
        chk("bp_crc_ok", crc_ok, 0);
        frame_rdy = 1'b1;
        tick();
        frame_rdy = 1'b0;
        chk("bp_xfer", frame_vld, 0);
        tick();
        chk("bp_idle", frame_vld, 0);

        // Timeout after 10 bits
        w32 = 32'hDEADBEEF;
        pulse(32, 1'b0, 4'd2);
        send_word(128'(w32 >> 22), 10, 1'b0);
        tn = 0;
        vseen = 1'b0;
        for (int j = 1; j <= 5000 && tn == 0; j++) begin
            tick();
            if (frame_vld) vseen = 1'b1;
            if (timeout) tn = j;
        end
        chk("to_cycles", tn, 4096);
        chk("to_no_vld", vseen, 0);
        tick();
        chk("to_width", timeout, 0);

        // Bit arrives in the limit cycle: no timeout
        pulse(32, 1'b0, 4'd2);
        send_word(128'(w32 >> 22), 10, 1'b0);
        tflag = 1'b0;
        repeat (4095) begin
            tick();
            if (timeout) tflag = 1'b1;
        end
        send_word(128'(w32 >> 21), 1, 1'b0);
        if (timeout) tflag = 1'b1;
        tick();
        if (timeout) tflag = 1'b1;
        send_word(128'(w32), 21, 1'b0);
        chk("nto_flag", tflag, 0);
        chk("nto_vld", frame_vld, 1);
        chk("nto_dat", frame_dat, 128'hDEADBEEF);
        chk("nto_bits", frame_bits, 32);
        frame_rdy = 1'b1;
        tick();
        frame_rdy = 1'b0;

        // Illegal lengths
        pulse(0, 1'b0, 4'd0);
        chk("len0_err", len_err, 1);
        chk("len0_vld", frame_vld, 0);
        tick();
        chk("len0_width", len_err, 0);
        pulse(129, 1'b0, 4'd0);
        chk("len129_err", len_err, 1);
        pulse(12, 1'b1, 4'd0);
        chk("len12crc_err", len_err, 1);
        send_word(128'hFFFF, 16, 1'b0);
        chk("len_idle_dat", frame_dat, 128'hDEADBEEF);
        chk("len_idle_bits", frame_bits, 32);

        // Asynchronous reset mid-frame
        pulse(16, 1'b0, 4'd5);
        send_word(128'hFFFF, 7, 1'b0);
        chk("mid_dat", frame_dat, 128'h7F);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dat", frame_dat, 128'h0);
        chk("arst_bits", frame_bits, 0);
        chk("arst_bank", frame_bank, 0);
        chk("arst_misc", {crc_ok, frame_vld, timeout, len_err, drop}, 0);
        tick();
        rst = 1'b1;
        send_word(128'hFFFF, 9, 1'b0);
        chk("arst_idle_dat", frame_dat, 128'h0);
        chk("arst_idle_vld", frame_vld, 0);

        // Restart mid-collect; coincident bit dropped
        pulse(16, 1'b0, 4'd2);
        send_word(128'hFFFF, 5, 1'b0);
        in_vld = 1'b1;
        in_dat = 1'b1;
        pulse(16, 1'b0, 4'd7);
        in_vld = 1'b0;
        chk("rs_cleared", frame_dat, 128'h0);
        chk("rs_no_to", timeout, 0);
        send_word(128'h1234, 16, 1'b0);
        chk("rs_vld", frame_vld, 1);
        chk("rs_dat", frame_dat, 128'h1234);
        chk("rs_bank", frame_bank, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
